// File: rtl/amba_ahb_arbiter_pkg.sv
// Shared AHB definitions for the bus arbiter.
// Provides the HTRANS and HBURST encodings, the arbiter state enum and
// burst_beats(), which returns the number of SEQ beats that follow the
// NONSEQ of a fixed-length burst (0 for SINGLE/INCR).
package amba_ahb_arbiter_pkg;

    localparam logic [1:0] H_IDLE   = 2'b00;
    localparam logic [1:0] H_BUSY   = 2'b01;
    localparam logic [1:0] H_NONSEQ = 2'b10;
    localparam logic [1:0] H_SEQ    = 2'b11;

    localparam logic [2:0] H_SINGLE = 3'b000;
    localparam logic [2:0] H_INCR   = 3'b001;
    localparam logic [2:0] H_WRAP4  = 3'b010;
    localparam logic [2:0] H_INCR4  = 3'b011;
    localparam logic [2:0] H_WRAP8  = 3'b100;
    localparam logic [2:0] H_INCR8  = 3'b101;
    localparam logic [2:0] H_WRAP16 = 3'b110;
    localparam logic [2:0] H_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BURST = 2'd1,
        LOCK  = 2'd2
    } arb_state_t;

    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst)
            H_WRAP4,  H_INCR4:  beats = 4'd3;
            H_WRAP8,  H_INCR8:  beats = 4'd7;
            H_WRAP16, H_INCR16: beats = 4'd15;
            default:            beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/amba_ahb_arbiter_rr_pick.sv
// Purely combinational round-robin priority picker.
// Ports:
//   req   - request vector, one bit per master
//   start - index searched first; the search wraps through all N masters
//   grant - one-hot winner (all zero when nothing requests)
//   valid - at least one request was found
module amba_ahb_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = W'((int'(start) + i) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/amba_ahb_arbiter.sv
// Round-robin AHB arbiter sharing one slave between MN masters.
// Fixed-length bursts and locked sequences are not interrupted.
// Ports:
//   hclk, hresetn - clock, asynchronous active-low reset
//   hbusreq       - per-master bus request
//   hlock         - per-master lock request
//   htrans/hburst - transfer/burst type on the muxed address bus
//   hready        - slave transfer done; every register holds while low
//   hgrant        - one-hot next address-phase owner
//   hmaster       - current address-phase owner
//   hmaster_d     - current data-phase owner (write/read data mux select)
//   hmastlock     - current address phase belongs to a locked sequence
// Handshake: a transfer is accepted on a rising hclk edge with hready=1;
// the arbiter only advances on such edges.
module amba_ahb_arbiter
    import amba_ahb_arbiter_pkg::*;
#(
    parameter int MN    = 4,
    parameter int MW    = 2,
    parameter int DEF_M = 0
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [MN-1:0] hbusreq,
    input  logic [MN-1:0] hlock,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hburst,
    input  logic          hready,
    output logic [MN-1:0] hgrant,
    output logic [MW-1:0] hmaster,
    output logic [MW-1:0] hmaster_d,
    output logic          hmastlock
);

    localparam logic [MN-1:0] DEF_GRANT = MN'(1) << DEF_M;

    arb_state_t    state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          rearb;
    logic          boundary;
    logic [MW-1:0] grant_idx;
    logic          lock_g;
    logic [MW-1:0] start_idx;
    logic [MN-1:0] pick_grant;
    logic          pick_valid;
    logic [MN-1:0] next_grant;
    logic [3:0]    beats;
    logic          fixed_start;

    // Index of the currently granted master (hgrant is one-hot).
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < MN; i++) begin
            if (hgrant[i]) grant_idx = MW'(i);
        end
    end

    assign lock_g      = hlock[grant_idx];
    assign start_idx   = (hmaster == MW'(MN - 1)) ? '0 : hmaster + 1'b1;
    assign beats       = burst_beats(hburst);
    assign fixed_start = (htrans == H_NONSEQ) && (beats != 4'd0);

    amba_ahb_rr_pick #(
        .N (MN),
        .W (MW)
    ) u_pick (
        .req   (hbusreq),
        .start (start_idx),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // With no requester the bus parks on the default master, which also
    // takes the grant away from a master that dropped its request.
    assign next_grant = pick_valid ? pick_grant : DEF_GRANT;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rearb    = 1'b0;
        boundary = 1'b0;
        case (state)
            ARB: begin
                cnt_n = fixed_start ? beats : 4'd0;
                if (lock_g)           state_n = LOCK;
                else if (fixed_start) state_n = BURST;
                else                  rearb   = 1'b1;
            end
            BURST: begin
                if (htrans == H_SEQ) begin
                    if (cnt == 4'd1) begin
                        cnt_n    = 4'd0;
                        boundary = 1'b1;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end else if (htrans == H_IDLE || htrans == H_NONSEQ) begin
                    // Early termination; a NONSEQ may immediately open a
                    // new fixed burst, which keeps the grant.
                    cnt_n    = fixed_start ? beats : 4'd0;
                    boundary = 1'b1;
                end
                if (boundary) begin
                    // A lock at the burst boundary wins over re-arbitration.
                    if (lock_g)              state_n = LOCK;
                    else if (cnt_n != 4'd0)  state_n = BURST;
                    else begin
                        state_n = ARB;
                        rearb   = 1'b1;
                    end
                end
            end
            LOCK: begin
                // Beats are tracked but never release the bus on their own.
                if (fixed_start)                          cnt_n = beats;
                else if (htrans == H_SEQ && cnt != 4'd0)  cnt_n = cnt - 4'd1;
                else if (htrans == H_IDLE || htrans == H_NONSEQ) cnt_n = 4'd0;
                if (!lock_g) begin
                    state_n = ARB;
                    cnt_n   = 4'd0;
                    rearb   = 1'b1;
                end
            end
            default: begin
                state_n = ARB;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ARB;
            cnt   <= 4'd0;
        end else if (hready) begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant    <= DEF_GRANT;
            hmaster   <= MW'(DEF_M);
            hmaster_d <= MW'(DEF_M);
            hmastlock <= 1'b0;
        end else if (hready) begin
            hmaster_d <= hmaster;
            hmaster   <= grant_idx;
            hmastlock <= lock_g;
            if (rearb) hgrant <= next_grant;
        end
    end

    grant_onehot_a: assert property (@(posedge hclk) disable iff (!hresetn)
        ($onehot(hgrant) && (int'(hmaster) < MN)));

endmodule

// File: tb/tb_amba_ahb_arbiter.sv
// Bench for amba_ahb_arbiter (MN=4, DEF_M=0): directed vector table,
// randomized run against a transaction-level reference model, and
// hand-written lock / early-termination / reset sequences.
module tb_amba_ahb_arbiter;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic [3:0] hbusreq = '0;
    logic [3:0] hlock = '0;
    logic [1:0] htrans = T_IDLE;
    logic [2:0] hburst = B_SINGLE;
    logic       hready = 1'b1;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_d;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 hclk = ~hclk;

    amba_ahb_arbiter #(.MN(4), .MW(2), .DEF_M(0)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks owners as plain integers; bursts as "beats still to come".
    int m_next, m_own, m_own_d, m_beats;
    bit m_lock_o, m_locked;

    task automatic model_reset();
        m_next = 0; m_own = 0; m_own_d = 0; m_beats = 0;
        m_lock_o = 0; m_locked = 0;
    endtask

    function automatic int fixed_len(input logic [1:0] t, input logic [2:0] b);
        int bi;
        bi = int'(b);
        if (t == T_NSEQ && bi >= 2) return (1 << (bi / 2 + 1)) - 1;
        return 0;
    endfunction

    task automatic model_step(input logic [3:0] req, input logic [3:0] lk,
                              input logic [1:0] t, input logic [2:0] b, input logic rdy);
        int g, len, pick;
        bit boundary, rearb;
        if (rdy) begin
            g = m_next;
            len = fixed_len(t, b);
            boundary = 0;
            rearb = 0;
            if (m_locked) begin
                if (len > 0) m_beats = len;
                else if (t == T_SEQ && m_beats > 0) m_beats--;
                else if (t == T_IDLE || t == T_NSEQ) m_beats = 0;
                if (!lk[g]) begin
                    m_locked = 0; m_beats = 0; rearb = 1;
                end
            end else begin
                if (m_beats > 0) begin
                    if (t == T_SEQ) begin
                        m_beats--;
                        if (m_beats == 0) boundary = 1;
                    end else if (t == T_IDLE || t == T_NSEQ) begin
                        m_beats = len;
                        boundary = 1;
                    end
                end else begin
                    boundary = 1;
                    m_beats = len;
                end
                if (boundary) begin
                    if (lk[g]) m_locked = 1;
                    else if (m_beats == 0) rearb = 1;
                end
            end
            pick = 0;
            for (int i = 4; i >= 1; i--) begin
                if (req[(m_own + i) % 4]) pick = (m_own + i) % 4;
            end
            m_own_d  = m_own;
            m_own    = g;
            m_lock_o = lk[g];
            if (rearb) m_next = pick;
        end
    endtask

    task automatic model_compare(input string tag);
        check({tag, ".hgrant"},    32'(hgrant),    32'(1 << m_next));
        check({tag, ".hmaster"},   32'(hmaster),   32'(m_own));
        check({tag, ".hmaster_d"}, 32'(hmaster_d), 32'(m_own_d));
        check({tag, ".hmastlock"}, 32'(hmastlock), 32'(m_lock_o));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] req, input logic [3:0] lk,
                         input logic [1:0] t, input logic [2:0] b, input logic rdy);
        hbusreq = req; hlock = lk; htrans = t; hburst = b; hready = rdy;
        @(posedge hclk);
        model_step(req, lk, t, b, rdy);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lk,
                        input logic [1:0] t, input logic [2:0] b, input logic rdy);
        drive(req, lk, t, b, rdy);
        model_compare(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".hgrant"},    32'(hgrant),    32'h1);
        check({tag, ".hmaster"},   32'(hmaster),   32'h0);
        check({tag, ".hmaster_d"}, 32'(hmaster_d), 32'h0);
        check({tag, ".hmastlock"}, 32'(hmastlock), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hresetn = 1'b0;
        hbusreq = '0; hlock = '0; htrans = T_IDLE; hburst = B_SINGLE; hready = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] req;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       rdy;
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] md;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic [3:0] req, input logic [1:0] t, input logic [2:0] b,
                                input logic rdy, input logic [3:0] g, input logic [1:0] m,
                                input logic [1:0] md);
        vec_t v;
        v.req = req; v.trans = t; v.burst = b; v.rdy = rdy; v.g = g; v.m = m; v.md = md;
        return v;
    endfunction

    logic [3:0] rl;

    initial begin
        vecs[0]  = mk(4'b0000, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 0);
        vecs[1]  = mk(4'b0110, T_IDLE, B_SINGLE, 1, 4'b0010, 0, 0);
        vecs[2]  = mk(4'b0110, T_IDLE, B_SINGLE, 1, 4'b0010, 1, 0);
        vecs[3]  = mk(4'b0110, T_IDLE, B_SINGLE, 1, 4'b0100, 1, 1);
        vecs[4]  = mk(4'b0010, T_IDLE, B_SINGLE, 1, 4'b0010, 2, 1);
        vecs[5]  = mk(4'b0010, T_IDLE, B_SINGLE, 1, 4'b0010, 1, 2);
        vecs[6]  = mk(4'b1111, T_NSEQ, B_INCR4,  1, 4'b0010, 1, 1);
        vecs[7]  = mk(4'b1111, T_SEQ,  B_INCR4,  1, 4'b0010, 1, 1);
        vecs[8]  = mk(4'b1111, T_SEQ,  B_INCR4,  0, 4'b0010, 1, 1);
        vecs[9]  = mk(4'b1111, T_SEQ,  B_INCR4,  0, 4'b0010, 1, 1);
        vecs[10] = mk(4'b1111, T_SEQ,  B_INCR4,  1, 4'b0010, 1, 1);
        vecs[11] = mk(4'b1111, T_SEQ,  B_INCR4,  1, 4'b0100, 1, 1);
        vecs[12] = mk(4'b1111, T_IDLE, B_SINGLE, 1, 4'b0100, 2, 1);
        vecs[13] = mk(4'b1111, T_IDLE, B_SINGLE, 1, 4'b1000, 2, 2);
        vecs[14] = mk(4'b0000, T_IDLE, B_SINGLE, 1, 4'b0001, 3, 2);
        vecs[15] = mk(4'b0000, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 3);

        model_reset();
        repeat (2) @(posedge hclk);
        #1;
        check_reset_vals("reset");
        @(negedge hclk);
        hresetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].req, 4'b0000, vecs[i].trans, vecs[i].burst, vecs[i].rdy);
            check($sformatf("vec%0d.hgrant", i),    32'(hgrant),    32'(vecs[i].g));
            check($sformatf("vec%0d.hmaster", i),   32'(hmaster),   32'(vecs[i].m));
            check($sformatf("vec%0d.hmaster_d", i), 32'(hmaster_d), 32'(vecs[i].md));
            check($sformatf("vec%0d.hmastlock", i), 32'(hmastlock), 32'h0);
        end

        // ---------------- randomized run against the model ----------------
        do_reset();
        rl = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0)
                rl = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
            step($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), rl,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0));
        end

        // ---------------- locked SINGLE sequence on master 2 ----------------
        do_reset();
        step("lk0", 4'b0100, 4'b0100, T_IDLE, B_SINGLE, 1);
        step("lk1", 4'b1111, 4'b0100, T_NSEQ, B_SINGLE, 1);
        step("lk2", 4'b1111, 4'b0100, T_NSEQ, B_SINGLE, 1);
        step("lk3", 4'b1111, 4'b0100, T_NSEQ, B_SINGLE, 1);
        check("lock_held.hgrant", 32'(hgrant), 32'b0100);
        check("lock_held.hmastlock", 32'(hmastlock), 32'h1);
        step("lk4", 4'b1111, 4'b0000, T_NSEQ, B_SINGLE, 1);
        check("lock_release.hgrant", 32'(hgrant), 32'b1000);
        check("lock_release.hmastlock", 32'(hmastlock), 32'h0);

        // ---------------- INCR8 on master 3 cut short by NONSEQ SINGLE ----------------
        step("b8_0", 4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1);
        step("b8_1", 4'b1001, 4'b0000, T_NSEQ, B_INCR8, 1);
        check("incr8_hold.hgrant", 32'(hgrant), 32'b1000);
        step("b8_2", 4'b1001, 4'b0000, T_SEQ, B_INCR8, 1);
        step("b8_3", 4'b1001, 4'b0000, T_BUSY, B_INCR8, 1);
        check("incr8_busy.hgrant", 32'(hgrant), 32'b1000);
        step("b8_4", 4'b1001, 4'b0000, T_NSEQ, B_SINGLE, 1);
        check("incr8_term.hgrant", 32'(hgrant), 32'b0001);

        // ---------------- reset mid-INCR16 ----------------
        step("b16_0", 4'b0001, 4'b0000, T_IDLE, B_SINGLE, 1);
        step("b16_1", 4'b1111, 4'b0000, T_NSEQ, B_INCR16, 1);
        for (int i = 0; i < 4; i++) step($sformatf("b16_s%0d", i), 4'b1111, 4'b0000, T_SEQ, B_INCR16, 1);
        hbusreq = 4'b1111; htrans = T_SEQ; hburst = B_INCR16;
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        check_reset_vals("mid_burst_reset");
        @(posedge hclk);
        #1;
        check_reset_vals("reset_held");
        @(negedge hclk);
        hresetn = 1'b1;
        model_reset();
        step("post_rst0", 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1);
        check("post_rst.hgrant", 32'(hgrant), 32'b0010);
        step("post_rst1", 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1);
        step("post_rst2", 4'b0110, 4'b0000, T_IDLE, B_SINGLE, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
